dab_meas_conditioner: RTL and testbench
=======================================

// Module: dab_meas_conditioner
// PURPOSE
//  Upstream of the DAB modulator/controller. Converts raw ADC samples of both DC-link voltages into
//  signed Q20.17 Vdc1/Vdc2 for controlador2. Each sample is offset-corrected, block-averaged over
//  2**AVG_LOG2 samples, gain-scaled and saturated. Results are published only on the actuator's
//  per-period trigger, so the controller sees one coherent pair per switching period.
//  Also raises a sticky over-voltage fault.
// PARAMETERS
//  ADC_BITS      12     raw ADC word width (unsigned)
//  BITS_ENTEROS  20     integer bits of output (output range [BITS_ENTEROS:-BITS_DECIMAL], 38 b)
//  BITS_DECIMAL  17     fractional bits of output
//  AVG_LOG2      3      log2 of samples per average (8), legal 0..6
//  OFFSET1/2     0      ADC code subtracted per channel (unsigned ADC_BITS)
//  GAIN1/2       13107  volts per LSB, signed Q20.17 (13107 = 0.1 V/LSB)
//  OV_LIMIT      50<<17 over-voltage threshold, signed Q20.17 (50.0 V)
// PORTS
//  clk       in   1    system clock (100 MHz)
//  rst       in   1    asynchronous reset, active-low
//  CE        in   1    clock enable; low = all state frozen
//  trigger   in   1    1-cycle pulse per DAB period from actuator
//  adc_valid in   1    sample strobe, 1 cycle per sample
//  adc_ch    in   1    0 = Vdc1, 1 = Vdc2
//  adc_data  in   12   raw sample
//  fault_clr in   1    clears ov_fault
//  Vdc1      out  38   signed Q20.17 published voltage, channel 0
//  Vdc2      out  38   signed Q20.17 published voltage, channel 1
//  data_rdy  out  1    1-cycle pulse when Vdc1/Vdc2 updated
//  stale     out  1    high if last trigger found no new data
//  ov_fault  out  1    sticky over-voltage flag
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, accumulators/counters 0, shadow_valid 0, FSM=ACC.
//  CE=0: no register changes; adc_valid, trigger and fault_clr ignored.
//  Sample path: d = {1'b0,adc_data} - OFFSETn (signed ADC_BITS+1), added into acc[adc_ch]
//    (width ADC_BITS+1+AVG_LOG2) and cnt[adc_ch]++.
//  A sample for a channel whose cnt is already 2**AVG_LOG2 is dropped.
//  FSM states:
//    ACC    -> SCALE1 in the cycle after both cnts are full.
//              On that transition: avg_n = acc_n >>> AVG_LOG2 (arithmetic), acc/cnt cleared.
//              A same-edge sample is accumulated into the cleared accumulator; none is lost.
//    SCALE1 -> SCALE2  p = avg_1 * GAIN1 (51 b signed), saturated to 38 b -> shadow1.
//    SCALE2 -> ACC     same for channel 2 -> shadow2; shadow_valid <= 1.
//    One shared multiplier; sampling continues in all states.
//  Latency: last filling sample accepted at edge k -> shadow_valid=1 after edge k+3.
//  Saturation: result > 2**37-1 -> 2**37-1; result < -2**37 -> -2**37.
//  Publish on trigger (CE=1):
//    shadow_valid=1: Vdc1/Vdc2 <= shadow1/2, data_rdy=1 next cycle, stale<=0, shadow_valid<=0.
//    shadow_valid=0: outputs hold, stale<=1, no data_rdy.
//    Trigger in the same cycle as SCALE2: sees the old shadow_valid and old shadow values;
//      the new pair is set valid for the next trigger.
//  ov_fault: set when a saturated shadow value > OV_LIMIT (either channel); sticky.
//    Cleared by fault_clr only.
//    If fault_clr and a new over-limit result coincide, set wins.
//  Reset mid-operation: partial averages discarded, outputs return to 0.
// TESTING
//  8x ch0=1000 and 8x ch1=500, OFFSET=0, then trigger
//    -> Vdc1=13107000, Vdc2=6553500, data_rdy 1 pulse, stale=0.
//  trigger before any full average -> Vdc1/2 stay 0, stale=1, no data_rdy.
//  interleaved samples, last at edge k -> shadow_valid at k+3.
//    Trigger at k+2 -> stale. Trigger at k+3 -> publishes.
//  ch0 = 4095, GAIN1 = 2**36 -> Vdc1 = 2**37-1 (saturated), ov_fault=1.
//    fault_clr -> ov_fault=0.
//  9 ch0 samples before any ch1 -> 9th dropped, average equals first 8.
//    Hold CE=0 for 5 cycles mid-accumulation -> counts unchanged.
//  assert rst mid-average -> all outputs 0 immediately. Next full average publishes correctly.

Source files
------------

// File: rtl/dab_meas_conditioner.sv
// dab_meas_conditioner
//   Conditions raw ADC samples of the two DAB DC-link voltages into signed
//   Q20.17 values for the controller. Each sample is offset-corrected and
//   block-averaged over 2**AVG_LOG2 samples per channel. The average is then
//   gain-scaled through one shared multiplier and saturated into a shadow
//   pair. The shadow pair is published to Vdc1/Vdc2 only on the actuator's
//   per-period trigger, so the controller always sees a coherent pair. A
//   sticky over-voltage fault is raised when either scaled value exceeds
//   OV_LIMIT.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   CE         clock enable; low freezes every register
//   trigger    one-cycle pulse per DAB period
//   adc_valid  sample strobe
//   adc_ch     sample channel (0 = Vdc1, 1 = Vdc2)
//   adc_data   raw unsigned ADC word
//   fault_clr  clears ov_fault
//   Vdc1/Vdc2  published signed Q20.17 voltages
//   data_rdy   one-cycle pulse after Vdc1/Vdc2 were updated
//   stale      last trigger found no new pair
//   ov_fault   sticky over-voltage flag
module dab_meas_conditioner #(
  parameter int ADC_BITS     = 12,
  parameter int BITS_ENTEROS = 20,
  parameter int BITS_DECIMAL = 17,
  parameter int AVG_LOG2     = 3,
  parameter logic [ADC_BITS-1:0] OFFSET1 = 12'd0,
  parameter logic [ADC_BITS-1:0] OFFSET2 = 12'd0,
  parameter logic signed [BITS_ENTEROS+BITS_DECIMAL:0] GAIN1    = 38'sd13107,
  parameter logic signed [BITS_ENTEROS+BITS_DECIMAL:0] GAIN2    = 38'sd13107,
  parameter logic signed [BITS_ENTEROS+BITS_DECIMAL:0] OV_LIMIT = 38'sd6553600
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    CE,
  input  logic                                    trigger,
  input  logic                                    adc_valid,
  input  logic                                    adc_ch,
  input  logic [ADC_BITS-1:0]                     adc_data,
  input  logic                                    fault_clr,
  output logic signed [BITS_ENTEROS+BITS_DECIMAL:0] Vdc1,
  output logic signed [BITS_ENTEROS+BITS_DECIMAL:0] Vdc2,
  output logic                                    data_rdy,
  output logic                                    stale,
  output logic                                    ov_fault
);

  localparam int DW = ADC_BITS + 1;                   // offset-corrected sample
  localparam int AW = ADC_BITS + 1 + AVG_LOG2;        // accumulator
  localparam int CW = AVG_LOG2 + 1;                   // sample counter
  localparam int OW = BITS_ENTEROS + BITS_DECIMAL + 1; // output word
  localparam int PW = DW + OW;                        // full product
  localparam logic [CW-1:0] FULL_CNT = CW'(1) << AVG_LOG2;

  typedef enum logic [1:0] {
    ST_ACC    = 2'd0,
    ST_SCALE1 = 2'd1,
    ST_SCALE2 = 2'd2
  } state_t;

  // Clamp a full-width product into the signed output word.
  function automatic logic signed [OW-1:0] sat_out(input logic signed [PW-1:0] p);
    logic [PW-OW:0] top;
    top = p[PW-1:OW-1];
    if (top == {(PW-OW+1){p[PW-1]}}) begin
      sat_out = p[OW-1:0];
    end else if (p[PW-1]) begin
      sat_out = {1'b1, {(OW-1){1'b0}}};
    end else begin
      sat_out = {1'b0, {(OW-1){1'b1}}};
    end
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic signed [AW-1:0]    acc_r [2];
  logic [CW-1:0]           cnt_r [2];
  logic signed [DW-1:0]    avg_r [2];
  logic signed [DW-1:0]    avg_next_s [2];
  logic                    take_s [2];
  logic signed [DW-1:0]    d_s;
  logic [ADC_BITS-1:0]     offset_s;
  logic                    start_s;
  logic signed [PW-1:0]    mul_a_s;
  logic signed [PW-1:0]    mul_b_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [OW-1:0]    sat_s;
  logic                    scaling_s;
  logic signed [OW-1:0]    shadow1_r;
  logic signed [OW-1:0]    shadow2_r;
  logic                    shadow_valid_r;

  // Offset correction, per-channel sample steering and average extraction.
  always_comb begin
    offset_s = adc_ch ? OFFSET2 : OFFSET1;
    d_s      = $signed({1'b0, adc_data}) - $signed({1'b0, offset_s});
    start_s  = (state_r == ST_ACC) && (cnt_r[0] == FULL_CNT) && (cnt_r[1] == FULL_CNT);
    for (int n = 0; n < 2; n++) begin
      take_s[n]     = adc_valid && (adc_ch == 1'(n));
      avg_next_s[n] = DW'(acc_r[n] >>> AVG_LOG2);
    end
  end

  // Shared multiplier: channel 1 in SCALE1, channel 2 otherwise.
  always_comb begin
    if (state_r == ST_SCALE1) begin
      mul_a_s = PW'(avg_r[0]);
      mul_b_s = PW'(GAIN1);
    end else begin
      mul_a_s = PW'(avg_r[1]);
      mul_b_s = PW'(GAIN2);
    end
    prod_s    = mul_a_s * mul_b_s;
    sat_s     = sat_out(prod_s);
    scaling_s = (state_r == ST_SCALE1) || (state_r == ST_SCALE2);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_ACC;
    end else if (CE) begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ACC: begin
        if (start_s) begin
          state_next_s = ST_SCALE1;
        end else begin
          state_next_s = ST_ACC;
        end
      end
      ST_SCALE1: state_next_s = ST_SCALE2;
      ST_SCALE2: state_next_s = ST_ACC;
      default:   state_next_s = ST_ACC;
    endcase
  end

  // Accumulators, counters and latched averages. When a block completes the
  // accumulator restarts from the same-edge sample so none is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        acc_r[n] <= '0;
        cnt_r[n] <= '0;
        avg_r[n] <= '0;
      end
    end else if (CE) begin
      for (int n = 0; n < 2; n++) begin
        if (start_s) begin
          avg_r[n] <= avg_next_s[n];
          if (take_s[n]) begin
            acc_r[n] <= AW'(d_s);
            cnt_r[n] <= CW'(1);
          end else begin
            acc_r[n] <= '0;
            cnt_r[n] <= '0;
          end
        end else if (take_s[n] && (cnt_r[n] != FULL_CNT)) begin
          acc_r[n] <= acc_r[n] + AW'(d_s);
          cnt_r[n] <= cnt_r[n] + CW'(1);
        end
      end
    end
  end

  // Shadow pair, trigger publishing and the sticky over-voltage flag.
  // A trigger during SCALE2 publishes the previous pair; the pair being
  // finished that cycle stays valid for the next trigger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow1_r      <= '0;
      shadow2_r      <= '0;
      shadow_valid_r <= 1'b0;
      Vdc1           <= '0;
      Vdc2           <= '0;
      data_rdy       <= 1'b0;
      stale          <= 1'b0;
      ov_fault       <= 1'b0;
    end else if (CE) begin
      if (state_r == ST_SCALE1) begin
        shadow1_r <= sat_s;
      end
      if (state_r == ST_SCALE2) begin
        shadow2_r <= sat_s;
      end

      if (state_r == ST_SCALE2) begin
        shadow_valid_r <= 1'b1;
      end else if (trigger) begin
        shadow_valid_r <= 1'b0;
      end

      if (trigger && shadow_valid_r) begin
        Vdc1     <= shadow1_r;
        Vdc2     <= shadow2_r;
        data_rdy <= 1'b1;
        stale    <= 1'b0;
      end else if (trigger) begin
        data_rdy <= 1'b0;
        stale    <= 1'b1;
      end else begin
        data_rdy <= 1'b0;
      end

      // Setting takes priority over a coincident clear.
      if (scaling_s && (sat_s > OV_LIMIT)) begin
        ov_fault <= 1'b1;
      end else if (fault_clr) begin
        ov_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dab_meas_conditioner.sv
// Directed bench for dab_meas_conditioner. A second instance with
// GAIN1 = 2**36 drives the saturation and over-voltage cases.
module tb_dab_meas_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CE = 1'b1;
  logic        trigger = 1'b0;
  logic        adc_valid = 1'b0;
  logic        adc_ch = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        fault_clr = 1'b0;

  logic signed [37:0] a_vdc1, a_vdc2, b_vdc1, b_vdc2;
  logic a_rdy, a_stale, a_ov, b_rdy, b_stale, b_ov;

  int checks = 0;
  int passes = 0;

  dab_meas_conditioner u_dut (
    .clk(clk), .rst(rst), .CE(CE), .trigger(trigger), .adc_valid(adc_valid),
    .adc_ch(adc_ch), .adc_data(adc_data), .fault_clr(fault_clr),
    .Vdc1(a_vdc1), .Vdc2(a_vdc2), .data_rdy(a_rdy), .stale(a_stale), .ov_fault(a_ov)
  );

  dab_meas_conditioner #(.GAIN1(38'sd68719476736)) u_sat (
    .clk(clk), .rst(rst), .CE(CE), .trigger(trigger), .adc_valid(adc_valid),
    .adc_ch(adc_ch), .adc_data(adc_data), .fault_clr(fault_clr),
    .Vdc1(b_vdc1), .Vdc2(b_vdc2), .data_rdy(b_rdy), .stale(b_stale), .ov_fault(b_ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic ch, input logic [11:0] v);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = v;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic fill(input logic [11:0] v0, input logic [11:0] v1);
    for (int i = 0; i < 8; i++) begin
      sample(1'b0, v0);
      sample(1'b1, v1);
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  // Wait until the shadow pair is valid (three edges after the last sample), then trigger.
  task automatic publish();
    tick();
    tick();
    tick();
    pulse_trigger();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_vdc1", 64'(a_vdc1), 64'd0);
    check("rst_vdc2", 64'(a_vdc2), 64'd0);
    check("rst_rdy", 64'(a_rdy), 64'd0);
    check("rst_stale", 64'(a_stale), 64'd0);
    check("rst_ov", 64'(a_ov), 64'd0);
    rst = 1'b1;
    tick();

    // Trigger before any full average
    pulse_trigger();
    check("early_stale", 64'(a_stale), 64'd1);
    check("early_rdy", 64'(a_rdy), 64'd0);
    check("early_vdc1", 64'(a_vdc1), 64'd0);

    // Basic averages; trigger during SCALE2 is stale, the next one publishes
    fill(12'd1000, 12'd500);
    tick();
    tick();
    pulse_trigger();
    check("k3_stale", 64'(a_stale), 64'd1);
    check("k3_rdy", 64'(a_rdy), 64'd0);
    check("k3_vdc1", 64'(a_vdc1), 64'd0);
    pulse_trigger();
    check("pub_vdc1", 64'(a_vdc1), 64'd13107000);
    check("pub_vdc2", 64'(a_vdc2), 64'd6553500);
    check("pub_rdy", 64'(a_rdy), 64'd1);
    check("pub_stale", 64'(a_stale), 64'd0);
    tick();
    check("pub_rdy_pulse", 64'(a_rdy), 64'd0);
    check("pub_ov", 64'(a_ov), 64'd1);
    pulse_clr();
    check("clr_ov", 64'(a_ov), 64'd0);

    // CE freeze mid-accumulation, then a ninth channel-0 sample is dropped
    for (int i = 0; i < 4; i++) sample(1'b0, 12'd100);
    CE        = 1'b0;
    adc_valid = 1'b1;
    adc_ch    = 1'b0;
    adc_data  = 12'd4095;
    trigger   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    CE        = 1'b1;
    adc_valid = 1'b0;
    trigger   = 1'b0;
    check("ce_stale", 64'(a_stale), 64'd0);
    check("ce_vdc1", 64'(a_vdc1), 64'd13107000);
    for (int i = 0; i < 4; i++) sample(1'b0, 12'd100);
    sample(1'b0, 12'd4095);
    for (int i = 0; i < 8; i++) sample(1'b1, 12'd200);
    publish();
    check("drop_vdc1", 64'(a_vdc1), 64'd1310700);
    check("drop_vdc2", 64'(a_vdc2), 64'd2621400);
    check("drop_rdy", 64'(a_rdy), 64'd1);
    check("drop_ov", 64'(a_ov), 64'd0);

    // Saturation and over-voltage on the high-gain instance
    pulse_clr();
    check("sat_ov_pre", 64'(b_ov), 64'd0);
    fill(12'd4095, 12'd0);
    publish();
    check("sat_vdc1", 64'(b_vdc1), 64'd137438953471);
    check("sat_vdc2", 64'(b_vdc2), 64'd0);
    check("sat_ov", 64'(b_ov), 64'd1);
    check("full_vdc1", 64'(a_vdc1), 64'd53673165);
    pulse_clr();
    check("sat_ov_clr", 64'(b_ov), 64'd0);

    // Reset mid-average
    pulse_trigger();
    check("pre_rst_stale", 64'(a_stale), 64'd1);
    for (int i = 0; i < 3; i++) sample(1'b0, 12'd4095);
    rst = 1'b0;
    #1;
    check("mid_rst_vdc1", 64'(a_vdc1), 64'd0);
    check("mid_rst_vdc2", 64'(a_vdc2), 64'd0);
    check("mid_rst_stale", 64'(a_stale), 64'd0);
    check("mid_rst_sat_vdc1", 64'(b_vdc1), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    fill(12'd300, 12'd400);
    publish();
    check("post_rst_vdc1", 64'(a_vdc1), 64'd3932100);
    check("post_rst_vdc2", 64'(a_vdc2), 64'd5242800);
    check("post_rst_rdy", 64'(a_rdy), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
